// File: rtl/mem_load_resp_queue.sv
// MEM-stage data-sram response queue: tracks in-order outstanding requests, extracts
// load data from each response and buffers results until the MEM stage takes them.
module mem_load_resp_queue #(
  parameter int DEPTH  = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_issue,
  input  logic [6:0]  req_ld_op,
  input  logic [1:0]  req_pos,
  input  logic        req_gr_we,
  output logic        req_ready,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [3:0]  resp_rf_we,
  output logic        resp_is_store,
  input  logic        flush,
  output logic        busy
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [6:0] ld_op;
    logic [1:0] pos;
    logic       gr_we;
  } tag_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  rf_we;
    logic        is_store;
  } res_t;

  tag_t          tag_mem [DEPTH];
  res_t          res_mem [DEPTH];
  logic [PW-1:0] tag_wptr, tag_rptr, res_wptr, res_rptr;
  logic [CW-1:0] pending_cnt, cancel_cnt, res_cnt;
  logic [CW:0]   occupancy;
  logic          tag_accept, dok, res_live, byp, res_push, res_pop;
  tag_t          head_tag;
  res_t          new_res, out_res;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ld_op one-hot order is {lw,lb,lbu,lh,lhu,lwl,lwr}; all-zero means store.
  function automatic res_t extract(input tag_t t, input logic [31:0] w);
    res_t        r;
    logic [7:0]  b;
    logic [15:0] h;
    b          = 8'(w >> {t.pos, 3'b000});
    h          = t.pos[1] ? w[31:16] : w[15:0];
    r.data     = '0;
    r.rf_we    = {4{t.gr_we}};
    r.is_store = 1'b0;
    if (t.ld_op == 7'd0) begin
      r.rf_we    = 4'b0000;
      r.is_store = 1'b1;
    end else if (t.ld_op[6]) r.data = w;
    else if (t.ld_op[5])     r.data = {{24{b[7]}}, b};
    else if (t.ld_op[4])     r.data = {24'd0, b};
    else if (t.ld_op[3])     r.data = {{16{h[15]}}, h};
    else if (t.ld_op[2])     r.data = {16'd0, h};
    else if (t.ld_op[1]) begin
      r.data  = w << {2'd3 - t.pos, 3'b000};
      r.rf_we = {1'b1, t.pos != 2'd0, t.pos[1], t.pos == 2'd3};
    end else begin
      r.data  = w >> {t.pos, 3'b000};
      r.rf_we = {t.pos == 2'd0, ~t.pos[1], t.pos != 2'd3, 1'b1};
    end
    return r;
  endfunction

  // Handshakes: a request is taken on req_issue && req_ready; a result leaves on
  // resp_valid && resp_ready. resp_valid never depends on resp_ready.
  assign occupancy  = {1'b0, pending_cnt} + {1'b0, res_cnt};
  assign req_ready  = !flush && (occupancy < (CW+1)'(DEPTH));
  // A request slipped in during flush is still tracked so its response can be cancelled.
  assign tag_accept = req_issue && (req_ready || (flush && pending_cnt < CW'(DEPTH)));
  assign dok        = data_sram_data_ok && (pending_cnt != '0);
  assign head_tag   = tag_mem[tag_rptr];
  assign new_res    = extract(head_tag, data_sram_rdata);
  assign res_live   = dok && (cancel_cnt == '0) && !flush;
  assign byp        = BYPASS && (res_cnt == '0) && res_live;
  assign resp_valid = !flush && ((res_cnt != '0) || byp);
  assign res_pop    = resp_valid && resp_ready && (res_cnt != '0);
  assign res_push   = res_live && !(byp && resp_ready);
  assign out_res    = (res_cnt != '0) ? res_mem[res_rptr] : new_res;
  assign resp_data     = out_res.data;
  assign resp_rf_we    = out_res.rf_we;
  assign resp_is_store = out_res.is_store;
  assign busy = (pending_cnt != '0) || (cancel_cnt != '0) || (res_cnt != '0);

  always_ff @(posedge clk) begin
    if (tag_accept) tag_mem[tag_wptr] <= '{ld_op: req_ld_op, pos: req_pos, gr_we: req_gr_we};
    if (res_push)   res_mem[res_wptr] <= new_res;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_wptr    <= '0;
      tag_rptr    <= '0;
      res_wptr    <= '0;
      res_rptr    <= '0;
      pending_cnt <= '0;
      cancel_cnt  <= '0;
      res_cnt     <= '0;
    end else begin
      if (tag_accept) tag_wptr <= ptr_inc(tag_wptr);
      if (dok)        tag_rptr <= ptr_inc(tag_rptr);
      pending_cnt <= pending_cnt + CW'(tag_accept) - CW'(dok);
      if (flush)
        cancel_cnt <= pending_cnt + CW'(tag_accept) - CW'(dok);
      else if (dok && cancel_cnt != '0)
        cancel_cnt <= cancel_cnt - 1'b1;
      if (flush) begin
        res_wptr <= '0;
        res_rptr <= '0;
        res_cnt  <= '0;
      end else begin
        if (res_push) res_wptr <= ptr_inc(res_wptr);
        if (res_pop)  res_rptr <= ptr_inc(res_rptr);
        res_cnt <= res_cnt + CW'(res_push) - CW'(res_pop);
      end
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(req_issue && flush && pending_cnt == CW'(DEPTH)));
  a_no_orphan_ok: assert property (@(posedge clk) disable iff (!resetn)
    !(data_sram_data_ok && pending_cnt == '0));
`endif
endmodule

// File: tb/tb_mem_load_resp_queue.sv
// Directed bench for mem_load_resp_queue: one BYPASS=1 and one BYPASS=0 instance on shared inputs.
module tb_mem_load_resp_queue;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_issue = 1'b0;
  logic [6:0]  req_ld_op = 7'd0;
  logic [1:0]  req_pos = 2'd0;
  logic        req_gr_we = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        resp_ready = 1'b0;
  logic        flush = 1'b0;

  logic        req_ready1, resp_valid1, resp_is_store1, busy1;
  logic [31:0] resp_data1;
  logic [3:0]  resp_rf_we1;
  logic        req_ready0, resp_valid0, resp_is_store0, busy0;
  logic [31:0] resp_data0;
  logic [3:0]  resp_rf_we0;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  localparam logic [6:0] OP_LW = 7'b1000000, OP_LB = 7'b0100000, OP_LBU = 7'b0010000,
                         OP_LH = 7'b0001000, OP_LHU = 7'b0000100, OP_LWL = 7'b0000010,
                         OP_LWR = 7'b0000001, OP_ST = 7'b0000000;

  mem_load_resp_queue #(.DEPTH(4), .BYPASS(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .req_issue(req_issue), .req_ld_op(req_ld_op),
    .req_pos(req_pos), .req_gr_we(req_gr_we), .req_ready(req_ready1),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .resp_valid(resp_valid1),
    .resp_ready(resp_ready), .resp_data(resp_data1), .resp_rf_we(resp_rf_we1),
    .resp_is_store(resp_is_store1), .flush(flush), .busy(busy1));

  mem_load_resp_queue #(.DEPTH(4), .BYPASS(1'b0)) dut0 (
    .clk(clk), .resetn(resetn), .req_issue(req_issue), .req_ld_op(req_ld_op),
    .req_pos(req_pos), .req_gr_we(req_gr_we), .req_ready(req_ready0),
    .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .resp_valid(resp_valid0),
    .resp_ready(resp_ready), .resp_data(resp_data0), .resp_rf_we(resp_rf_we0),
    .resp_is_store(resp_is_store0), .flush(flush), .busy(busy0));

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [1:0] pos);
    req_issue = 1'b1;
    req_ld_op = op;
    req_pos   = pos;
    req_gr_we = 1'b1;
    tick();
    req_issue = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  // table for single-request extraction cases
  logic [6:0]  t_op   [6] = '{OP_LB, OP_LHU, OP_LWR, OP_ST, OP_LH, OP_LBU};
  logic [1:0]  t_pos  [6] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1};
  logic [31:0] t_rd   [6] = '{32'h8000_0000, 32'h8001_0000, 32'hAABB_CCDD,
                              32'hFFFF_FFFF, 32'h0000_8001, 32'h0000_F000};
  logic [31:0] t_data [6] = '{32'hFFFF_FF80, 32'h0000_8001, 32'h00AA_BBCC,
                              32'h0000_0000, 32'hFFFF_8001, 32'h0000_00F0};
  logic [3:0]  t_we   [6] = '{4'hF, 4'hF, 4'h7, 4'h0, 4'hF, 4'hF};
  logic        t_st   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    #2;
    check("reset_resp_valid", resp_valid1, 1'b0);
    check("reset_busy", busy1, 1'b0);
    check("reset_req_ready", req_ready1, 1'b1);
    resetn = 1'b1;
    tick();

    // reset in the middle of traffic
    for (int i = 0; i < 3; i++) issue(OP_LW, 2'd0);
    #2;
    check("t1_busy_before", busy1, 1'b1);
    check("t1_req_ready_before", req_ready1, 1'b1);
    resetn = 1'b0;
    #1;
    check("t1_resp_valid", resp_valid1, 1'b0);
    check("t1_busy", busy1, 1'b0);
    check("t1_req_ready", req_ready1, 1'b1);
    tick();
    resetn = 1'b1;
    tick();

    // lw then lwl with bypass
    resp_ready = 1'b1;
    issue(OP_LW, 2'd0);
    issue(OP_LWL, 2'd1);
    data_ok = 1'b1;
    rdata   = 32'h1122_3344;
    #2;
    check("t2_lw_valid", resp_valid1, 1'b1);
    check("t2_lw_data", resp_data1, 32'h1122_3344);
    check("t2_lw_we", resp_rf_we1, 4'hF);
    check("t2_nobyp_valid", resp_valid0, 1'b0);
    tick();
    rdata = 32'hAABB_CCDD;
    #2;
    check("t2_lwl_valid", resp_valid1, 1'b1);
    check("t2_lwl_data", resp_data1, 32'hCCDD_0000);
    check("t2_lwl_we", resp_rf_we1, 4'b1100);
    tick();
    data_ok = 1'b0;
    tick();
    check("t2_idle_valid", resp_valid1, 1'b0);
    check("t2_idle_busy", busy1, 1'b0);

    // extraction table
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_pos[i]);
      data_ok = 1'b1;
      rdata   = t_rd[i];
      #2;
      check($sformatf("t3_valid_%0d", i), resp_valid1, 1'b1);
      check($sformatf("t3_data_%0d", i), resp_data1, t_data[i]);
      check($sformatf("t3_we_%0d", i), resp_rf_we1, t_we[i]);
      check($sformatf("t3_store_%0d", i), resp_is_store1, t_st[i]);
      tick();
      data_ok = 1'b0;
      tick();
    end

    // fill to DEPTH with the consumer stalled
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check($sformatf("t4_ready_pre_%0d", i), req_ready1, 1'b1);
      issue(OP_LW, 2'd0);
    end
    #2;
    check("t4_ready_full", req_ready1, 1'b0);
    issue(OP_LW, 2'd0);
    for (int i = 0; i < 4; i++) begin
      data_ok = 1'b1;
      rdata   = 32'h1000 + 32'(i);
      exp_q.push_back(rdata);
      tick();
    end
    data_ok = 1'b0;
    #2;
    check("t4_ready_buffered", req_ready1, 1'b0);
    check("t4_valid_buffered", resp_valid1, 1'b1);
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t4_drain_%0d", i), resp_data1, exp_q.pop_front());
      tick();
      if (i == 0) check("t4_ready_after_pop", req_ready1, 1'b1);
    end
    #2;
    check("t4_valid_empty", resp_valid1, 1'b0);
    check("t4_busy_empty", busy1, 1'b0);

    // flush with a response in the same cycle
    issue(OP_LW, 2'd0);
    issue(OP_LW, 2'd0);
    flush   = 1'b1;
    data_ok = 1'b1;
    rdata   = 32'h0000_DEAD;
    #2;
    check("t5_flush_valid", resp_valid1, 1'b0);
    check("t5_flush_ready", req_ready1, 1'b0);
    tick();
    flush   = 1'b0;
    data_ok = 1'b0;
    #2;
    check("t5_busy_cancel", busy1, 1'b1);
    check("t5_ready_post", req_ready1, 1'b1);
    issue(OP_LW, 2'd0);
    data_ok = 1'b1;
    rdata   = 32'h0000_0BAD;
    #2;
    check("t5_stale_dropped", resp_valid1, 1'b0);
    tick();
    rdata = 32'h0000_600D;
    #2;
    check("t5_new_valid", resp_valid1, 1'b1);
    check("t5_new_data", resp_data1, 32'h0000_600D);
    tick();
    data_ok = 1'b0;
    #2;
    check("t5_busy_done", busy1, 1'b0);

    // registered path latency
    do_reset();
    resp_ready = 1'b0;
    issue(OP_LW, 2'd0);
    data_ok = 1'b1;
    rdata   = 32'h1234_5678;
    #2;
    check("t6_nobyp_same_cycle", resp_valid0, 1'b0);
    check("t6_byp_same_cycle", resp_valid1, 1'b1);
    tick();
    data_ok = 1'b0;
    rdata   = 32'h0;
    #2;
    check("t6_nobyp_next_valid", resp_valid0, 1'b1);
    check("t6_nobyp_next_data", resp_data0, 32'h1234_5678);
    check("t6_nobyp_next_we", resp_rf_we0, 4'hF);
    resp_ready = 1'b1;
    tick();
    #2;
    check("t6_nobyp_busy", busy0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
